// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared CPU widths, opcode field position and opcode constants.
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 16;

  // Opcode lives in the top nibble of every instruction word
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_ADDI = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_MULT = 4'b0100,
    OP_DISP = 4'b0101,
    OP_STUR = 4'b0110,
    OP_LDUR = 4'b0111,
    OP_HALT = 4'b1001
  } opcode_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ============================================================================
// instr_fetch_if : imem port, decode-side instruction stream and redirect bus.
// Rev 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_if #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
);

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    instr_pc;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halted;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr_out,
    output instr_pc,
    input  redirect_valid,
    input  redirect_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr_out,
    input  instr_pc,
    output redirect_valid,
    output redirect_pc,
    input  halted
  );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : prefetch buffer of {instr, pc} entries with flush; DEPTH 2 or 4.
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 20
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic             pop,
  input  wire logic             flush,
  output logic      [WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // full/empty are registered so downstream sees a clean flop-driven valid
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : PC sequencing, redirect and halt control feeding fetch_fifo.
// Optional halt detection enabled by macro FETCH_HALT_DETECT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int                         PC_W    = cpu_pkg::PC_W,
  parameter int                         INSTR_W = cpu_pkg::INSTR_W,
  parameter int                         DEPTH   = 2,
  parameter logic [cpu_pkg::OPC_W-1:0]  HALT_OP = cpu_pkg::OP_HALT
) (
  input wire logic      clk,
  input wire logic      rst,
  instr_fetch_if.master bus
);

  import cpu_pkg::*;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [PC_W-1:0]         pc;
  logic                    halted_q;
  logic                    full;
  logic                    empty;
  logic                    fetch;
  logic                    pop;
  logic                    halt_hit;
  logic [INSTR_W+PC_W-1:0] head;

  // A full buffer blocks fetch outright, so push and pop never meet on full
  assign fetch    = !bus.redirect_valid && !halted_q && !full;
  assign pop      = bus.instr_ready && !empty;
  assign halt_hit = HALT_EN && fetch && (bus.imem_rdata[OPC_MSB:OPC_LSB] == HALT_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      halted_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc       <= bus.redirect_pc;
      halted_q <= 1'b0;
    end else begin
      if (fetch)    pc       <= pc + 1'b1;
      if (halt_hit) halted_q <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W + PC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .wdata ({bus.imem_rdata, pc}),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.imem_addr   = pc;
  assign bus.instr_valid = !empty;
  assign bus.instr_out   = head[INSTR_W+PC_W-1:PC_W];
  assign bus.instr_pc    = head[PC_W-1:0];
  assign bus.halted      = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch : vector table, directed corner sequences and random run
// against a queue-based reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam int DEPTH = 2;
  localparam int NV    = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  logic [15:0] imem [16];
  assign bus.imem_rdata = imem[bus.imem_addr];

  instr_fetch #(
    .PC_W    (4),
    .INSTR_W (16),
    .DEPTH   (DEPTH),
    .HALT_OP (4'b1001)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          rst;
    bit          ready;
    bit          redir;
    bit          e_valid;
    logic [15:0] e_instr;
    logic [3:0]  e_pc;
    logic [3:0]  e_addr;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  pc;
  } ent_t;

  vec_t tbl [NV];
  ent_t mq [$];
  logic [3:0] mpc;
  bit mhalt;

  function automatic vec_t mk(bit r, bit rdy, bit rv, bit v, logic [15:0] ins,
                              logic [3:0] p, logic [3:0] a);
    vec_t t;
    t.rst = r; t.ready = rdy; t.redir = rv; t.e_valid = v;
    t.e_instr = ins; t.e_pc = p; t.e_addr = a;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit rdy, input bit rv, input logic [3:0] rp);
    rst                = r;
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input bit v, input logic [15:0] ins,
                           input logic [3:0] p, input logic [3:0] a, input bit h);
    chk({tag, ".valid"},  bus.instr_valid, v);
    chk({tag, ".addr"},   bus.imem_addr, a);
    chk({tag, ".halted"}, bus.halted, h);
    if (v) begin
      chk({tag, ".instr"}, bus.instr_out, ins);
      chk({tag, ".pc"},    bus.instr_pc, p);
    end
  endtask

  task automatic load_imem();
    for (int i = 0; i < 16; i++) imem[i] = 16'h5000 + 16'(i);
    imem[0] = 16'h1123; imem[1] = 16'h0456; imem[2] = 16'h2789; imem[3] = 16'h3ABC;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit r, rdy, rv, cf;
    logic [3:0] rp;
    logic [3:0] op;

    drive(1'b1, 1'b0, 1'b0, 4'h0);
    load_imem();

    // Startup stream, then a 5-cycle stall and in-order release
    tbl[0]  = mk(1, 1, 1, 0, 16'h0000, 4'h0, 4'h0);
    tbl[1]  = mk(0, 1, 0, 1, 16'h1123, 4'h0, 4'h1);
    tbl[2]  = mk(0, 1, 0, 1, 16'h0456, 4'h1, 4'h2);
    tbl[3]  = mk(0, 1, 0, 1, 16'h2789, 4'h2, 4'h3);
    tbl[4]  = mk(0, 1, 0, 1, 16'h3ABC, 4'h3, 4'h4);
    tbl[5]  = mk(1, 1, 1, 0, 16'h0000, 4'h0, 4'h0);
    tbl[6]  = mk(0, 0, 0, 1, 16'h1123, 4'h0, 4'h1);
    tbl[7]  = mk(0, 0, 0, 1, 16'h1123, 4'h0, 4'h2);
    tbl[8]  = mk(0, 0, 0, 1, 16'h1123, 4'h0, 4'h2);
    tbl[9]  = mk(0, 0, 0, 1, 16'h1123, 4'h0, 4'h2);
    tbl[10] = mk(0, 0, 0, 1, 16'h1123, 4'h0, 4'h2);
    tbl[11] = mk(0, 1, 0, 1, 16'h0456, 4'h1, 4'h2);
    tbl[12] = mk(0, 1, 0, 1, 16'h2789, 4'h2, 4'h3);
    tbl[13] = mk(0, 1, 0, 1, 16'h3ABC, 4'h3, 4'h4);
    tbl[14] = mk(0, 1, 0, 1, 16'h5004, 4'h4, 4'h5);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].ready, tbl[i].redir, 4'h7);
      tick();
      chk_state($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_instr,
                tbl[i].e_pc, tbl[i].e_addr, 1'b0);
    end

    // Halt opcode at address 2
    load_imem();
    imem[2] = 16'h9000;
    drive(1, 1, 0, 4'h0); tick(); chk_state("halt.rst", 0, 16'h0, 4'h0, 4'h0, 0);
    drive(0, 1, 0, 4'h0); tick(); chk_state("halt.c1", 1, 16'h1123, 4'h0, 4'h1, 0);
    tick(); chk_state("halt.c2", 1, 16'h0456, 4'h1, 4'h2, 0);
    tick(); chk_state("halt.c3", 1, 16'h9000, 4'h2, 4'h3, HALT_EN);
    tick();
`ifdef FETCH_HALT_DETECT_EN
    chk_state("halt.c4", 0, 16'h0, 4'h0, 4'h3, 1);
    tick(); chk_state("halt.c5", 0, 16'h0, 4'h0, 4'h3, 1);
`else
    chk_state("halt.c4", 1, 16'h3ABC, 4'h3, 4'h4, 0);
`endif

    // Redirect on a full buffer with wrap past 0xF
    load_imem();
    imem[14] = 16'h1E0E; imem[15] = 16'h1F0F;
    drive(1, 0, 0, 4'h0); tick();
    drive(0, 0, 0, 4'h0); tick(); tick();
    chk_state("redir.full", 1, 16'h1123, 4'h0, 4'h2, 0);
    drive(0, 1, 1, 4'hE); tick(); chk_state("redir.flush", 0, 16'h0, 4'h0, 4'hE, 0);
    drive(0, 1, 0, 4'h0); tick(); chk_state("redir.e", 1, 16'h1E0E, 4'hE, 4'hF, 0);
    tick(); chk_state("redir.f", 1, 16'h1F0F, 4'hF, 4'h0, 0);
    tick(); chk_state("redir.wrap", 1, 16'h1123, 4'h0, 4'h1, 0);

    // Reset pulse with a full, halted buffer; rst beats ready and redirect
    load_imem();
    imem[1] = 16'h9000;
    drive(1, 0, 0, 4'h0); tick();
    drive(0, 0, 0, 4'h0); tick(); tick();
    chk_state("rst.pre", 1, 16'h1123, 4'h0, 4'h2, HALT_EN);
    drive(1, 1, 1, 4'h9); tick(); chk_state("rst.mid", 0, 16'h0, 4'h0, 4'h0, 0);
    drive(0, 1, 0, 4'h0); tick(); chk_state("rst.restart", 1, 16'h1123, 4'h0, 4'h1, 0);

    // Random traffic against the reference model
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 9));
      if (op == 4'h8) op = 4'h9;
      imem[i] = {op, 12'($urandom)};
    end
    mpc = 4'h0;
    mhalt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r   = (c == 0) || ($urandom_range(0, 99) < 2);
      rdy = $urandom_range(0, 99) < 70;
      rv  = $urandom_range(0, 99) < 6;
      rp  = 4'($urandom);
      drive(r, rdy, rv, rp);
      @(posedge clk);
      if (r) begin
        mq.delete(); mpc = 4'h0; mhalt = 1'b0;
      end else if (rv) begin
        mq.delete(); mpc = rp; mhalt = 1'b0;
      end else begin
        cf = !mhalt && (mq.size() < DEPTH);
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (cf) begin
          mq.push_back('{imem[mpc], mpc});
          if (HALT_EN && imem[mpc][15:12] == 4'h9) mhalt = 1'b1;
          mpc = mpc + 4'h1;
        end
      end
      #1;
      chk("rand.valid",  bus.instr_valid, mq.size() != 0);
      chk("rand.addr",   bus.imem_addr, mpc);
      chk("rand.halted", bus.halted, mhalt);
      if (mq.size() != 0) begin
        chk("rand.instr", bus.instr_out, mq[0].instr);
        chk("rand.pc",    bus.instr_pc, mq[0].pc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 4, program-counter and imem address width.
REQ-002 Parameter INSTR_W, default 16, instruction width.
REQ-003 Parameter DEPTH, default 2, prefetch buffer entries; legal values are 2 and 4.
REQ-004 Parameter HALT_OP, default 4'b1001, opcode (instr[15:12]) that halts fetch.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 imem_addr  output  PC_W  fetch address to instruction memory; equals the current PC.
REQ-008 imem_rdata  input  INSTR_W  instruction memory read data; combinational, valid in the same cycle as imem_addr.
REQ-009 instr_valid  output  1  buffer head holds a valid instruction.
REQ-010 instr_ready  input  1  downstream decode/execute stage accepts the head.
REQ-011 instr_out  output  INSTR_W  head instruction.
REQ-012 instr_pc  output  PC_W  address the head instruction was fetched from.
REQ-013 redirect_valid  input  1  flush the buffer and restart fetch at redirect_pc.
REQ-014 redirect_pc  input  PC_W  new fetch address.
REQ-015 halted  output  1  halt opcode fetched; no further fetches.

Function
REQ-016 Fetch: in any cycle with no redirect, not halted and the buffer not full, the block SHALL enqueue {imem_rdata, PC} and set PC to PC+1 modulo 2^PC_W (15 wraps to 0).
REQ-017 Buffer full or halted: PC SHALL hold and no enqueue SHALL occur.
REQ-018 Dequeue: the head SHALL be removed on a rising edge where instr_valid && instr_ready; instr_valid SHALL be a registered, non-empty flag.
REQ-019 Simultaneous enqueue and dequeue on a full buffer SHALL NOT be allowed (a full buffer blocks fetch); on a non-full, non-empty buffer both SHALL take effect and occupancy SHALL stay unchanged.
REQ-020 Latency: the first instruction after reset deassertion SHALL present instr_valid=1 one cycle later; with instr_ready held high, throughput SHALL be one instruction per cycle.
REQ-021 Buffer order SHALL be FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-022 Halt: when an enqueued instruction has opcode HALT_OP, it SHALL be enqueued and halted SHALL go to 1 on the same edge; fetch SHALL stop; already-buffered instructions SHALL still drain.
REQ-023 Redirect SHALL have priority: on that edge the buffer SHALL empty, PC SHALL load redirect_pc, halted SHALL clear, and any same-cycle fetch or dequeue SHALL be discarded.
REQ-024 The fetch after a redirect SHALL occur in the following cycle from redirect_pc; instr_valid SHALL be 0 for exactly that one cycle.
REQ-025 instr_out and instr_pc SHALL be don't-care while instr_valid=0; the bench SHALL NOT check them then.

Reset
REQ-026 On a rising edge with rst=1: PC=0, buffer empty, instr_valid=0, halted=0; rst SHALL override redirect_valid and instr_ready.
REQ-027 Reset asserted mid-stream SHALL drop all buffered instructions; after release, fetch SHALL restart at address 0.

Configuration
REQ-028 Macro FETCH_HALT_DETECT_EN defined: halt behaviour is per REQ-022.
REQ-029 FETCH_HALT_DETECT_EN undefined: HALT_OP SHALL be fetched as an ordinary instruction, halted SHALL be tied 0, and fetch SHALL never self-stop.

Structure
REQ-030 Shared package cpu_pkg SHALL hold PC_W, INSTR_W, the opcode field position and the opcode constants (ADD, ADDI, AND, OR, MULT, DISP, STUR, LDUR, HALT); instr_fetch SHALL take HALT_OP from it.
REQ-031 The prefetch buffer SHALL be the sub-module fetch_fifo, holding {instr, pc} entries with push, pop, flush, full and empty signals; PC and halt logic SHALL stay in instr_fetch.

Verification
REQ-032 Reset, imem[0..3]=0x1123,0x0456,0x2789,0x3ABC, instr_ready=1 -> instr_valid high from the 2nd cycle; instr_out sequence 0x1123,0x0456,0x2789,0x3ABC with instr_pc 0,1,2,3.
REQ-033 instr_ready=0 for 5 cycles -> PC stops at DEPTH, instr_out holds 0x1123; on release -> in-order output with no loss or duplication.
REQ-034 imem[2]=0x9000, macro defined -> halted=1 after pc 2 is enqueued; 0x9000 delivered last; imem_addr frozen at 3; with macro undefined -> pc 3 fetched, halted=0.
REQ-035 Buffer full with 2 entries, redirect_valid=1 with redirect_pc=0xE while instr_ready=1 -> nothing dequeued, instr_valid=0 one cycle, then pc 0xE,0xF,0x0 in order (wrap).
REQ-036 rst pulsed for 1 cycle while 2 entries are buffered and halted=1 -> all outputs at reset values; restart at pc 0.
